// File: rtl/vending_pkg.sv
// Shared types and default sizing for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_DISPENSE,
    S_DONE
  } state_e;

  localparam int DEF_N_PROD     = 4;
  localparam int DEF_N_ING      = 5;
  localparam int DEF_CREDIT_W   = 8;
  localparam int DEF_MAX_CREDIT = 11;
  localparam int DEF_TIME_W     = 4;
  localparam int DEF_TICK_DIV   = 50_000_000;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vending_ctrl_param_tick_gen.sv
// Enable-tick divider: pulses tick every TICK_DIV enabled cycles.
module tick_gen
  import vending_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = safe_clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (clr) begin
      div_d = '0;
    end else if (en) begin
      div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
    end
  end

  assign tick = en && (div_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vending_ctrl_param.sv
// Drink-vending controller: credit, priced selection, timed valves, change.
module vending_ctrl_param
  import vending_pkg::*;
#(
  parameter int N_PROD     = DEF_N_PROD,
  parameter int N_ING      = DEF_N_ING,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int TIME_W     = DEF_TIME_W,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             coin_valid,
  input  logic [CREDIT_W-1:0]              coin_units,
  input  logic                             sel_valid,
  input  logic [safe_clog2(N_PROD)-1:0]    sel_id,
  input  logic                             cancel,
  input  logic                             take,
  input  logic [N_PROD*CREDIT_W-1:0]       price_tbl,
  input  logic [N_PROD*N_ING*TIME_W-1:0]   recipe_tbl,
  output logic [N_ING-1:0]                 ing_on,
  output logic                             drink_ready,
  output logic [CREDIT_W-1:0]              credit,
  output logic                             change_valid,
  output logic [CREDIT_W-1:0]              change_units,
  output logic                             coin_reject,
  output logic                             insufficient,
  output logic                             busy
);

  localparam int SEL_W = safe_clog2(N_PROD);
  localparam int IDX_W = safe_clog2(N_ING);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [CREDIT_W-1:0] chg_units_q, chg_units_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic load_q, load_d;
  logic [N_ING-1:0] ing_on_q, ing_on_d;
  logic drink_q, drink_d;
  logic chg_valid_q, chg_valid_d;
  logic coin_rej_q, coin_rej_d;
  logic insuff_q, insuff_d;
  logic busy_q, busy_d;

  logic [CREDIT_W:0] sum;
  logic [CREDIT_W-1:0] price;
  logic [TIME_W-1:0] t_cur;
  logic in_pay, do_cancel, do_sel, do_coin, fits;
  logic advance, last_ing, tick, div_clr, div_en;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  assign div_clr = (state_q == S_DISPENSE) && load_q;
  assign div_en  = (state_q == S_DISPENSE) && !load_q;

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    change_d    = change_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    ing_on_d    = ing_on_q;
    drink_d     = drink_q;
    chg_valid_d = 1'b0;
    chg_units_d = '0;
    insuff_d    = 1'b0;
    advance     = 1'b0;

    sum   = {1'b0, credit_q} + {1'b0, coin_units};
    fits  = (sum <= MAX_C);
    price = price_tbl[int'(sel_id)*CREDIT_W +: CREDIT_W];
    t_cur = recipe_tbl[(int'(sel_q)*N_ING + int'(idx_q))*TIME_W +: TIME_W];
    last_ing = (idx_q == IDX_W'(N_ING - 1));

    in_pay    = (state_q == S_IDLE) || (state_q == S_CREDIT);
    do_cancel = cancel && (state_q == S_CREDIT);
    do_sel    = sel_valid && in_pay && !do_cancel;
    do_coin   = coin_valid && in_pay && !do_cancel && !do_sel;
    // Any coin not actually credited is bounced back to the customer.
    coin_rej_d = coin_valid && !(do_coin && fits);

    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        unique case (1'b1)
          do_cancel: begin
            chg_valid_d = 1'b1;
            chg_units_d = credit_q;
            credit_d    = '0;
            state_d     = S_IDLE;
          end
          do_sel: begin
            if (state_q == S_CREDIT && credit_q >= price) begin
              sel_d    = sel_id;
              change_d = credit_q - price;
              credit_d = '0;
              idx_d    = '0;
              load_d   = 1'b1;
              state_d  = S_DISPENSE;
            end else begin
              insuff_d = 1'b1;
            end
          end
          (do_coin && fits): begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end
          default: ;
        endcase
      end
      S_DISPENSE: begin
        if (load_q) begin
          if (t_cur != '0) begin
            ing_on_d = N_ING'(1) << idx_q;
            cnt_d    = t_cur;
            load_d   = 1'b0;
          end else begin
            advance = 1'b1;
          end
        end else if (tick) begin
          if (cnt_q == TIME_W'(1)) begin
            ing_on_d = '0;
            advance  = 1'b1;
          end else begin
            cnt_d = cnt_q - TIME_W'(1);
          end
        end
        if (advance) begin
          if (last_ing) begin
            state_d     = S_DONE;
            drink_d     = 1'b1;
            chg_valid_d = 1'b1;
            chg_units_d = change_q;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            load_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (take) begin
          drink_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DISPENSE) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      change_q    <= '0;
      chg_units_q <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      load_q      <= 1'b0;
      ing_on_q    <= '0;
      drink_q     <= 1'b0;
      chg_valid_q <= 1'b0;
      coin_rej_q  <= 1'b0;
      insuff_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      change_q    <= change_d;
      chg_units_q <= chg_units_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      load_q      <= load_d;
      ing_on_q    <= ing_on_d;
      drink_q     <= drink_d;
      chg_valid_q <= chg_valid_d;
      coin_rej_q  <= coin_rej_d;
      insuff_q    <= insuff_d;
      busy_q      <= busy_d;
    end
  end

  assign ing_on       = ing_on_q;
  assign drink_ready  = drink_q;
  assign credit       = credit_q;
  assign change_valid = chg_valid_q;
  assign change_units = chg_units_q;
  assign coin_reject  = coin_rej_q;
  assign insufficient = insuff_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Randomised and directed bench for vending_ctrl_param against a schedule model.
module tb_vending_ctrl_param;

  localparam int NP = 4;
  localparam int NI = 5;
  localparam int CW = 8;
  localparam int MAXC = 11;
  localparam int TW = 4;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  logic coin_valid;
  logic [CW-1:0] coin_units;
  logic sel_valid;
  logic [1:0] sel_id;
  logic cancel;
  logic take;
  logic [NP*CW-1:0] price_tbl;
  logic [NP*NI*TW-1:0] recipe_tbl;
  logic [NI-1:0] ing_on;
  logic drink_ready;
  logic [CW-1:0] credit;
  logic change_valid;
  logic [CW-1:0] change_units;
  logic coin_reject;
  logic insufficient;
  logic busy;

  always #5 clk = ~clk;

  vending_ctrl_param #(
    .N_PROD(NP), .N_ING(NI), .CREDIT_W(CW),
    .MAX_CREDIT(MAXC), .TIME_W(TW), .TICK_DIV(TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_units   (coin_units),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .take         (take),
    .price_tbl    (price_tbl),
    .recipe_tbl   (recipe_tbl),
    .ing_on       (ing_on),
    .drink_ready  (drink_ready),
    .credit       (credit),
    .change_valid (change_valid),
    .change_units (change_units),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .busy         (busy)
  );

  int checks = 0;
  int failures = 0;
  int prices[NP] = '{3, 4, 5, 7};
  int rec[NP][NI];
  int on_cnt[NI];

  // Model: 0 idle, 1 credit, 2 dispense, 3 done
  int m_mode, m_credit, m_change;
  int sched[$];
  int e_ing, e_ready, e_credit, e_cv, e_cu, e_rej, e_ins, e_busy;

  task automatic pack_tables();
    for (int p = 0; p < NP; p++) begin
      price_tbl[p*CW +: CW] = CW'(prices[p]);
      for (int i = 0; i < NI; i++)
        recipe_tbl[(p*NI+i)*TW +: TW] = TW'(rec[p][i]);
    end
  endtask

  // Expected valve word for each cycle after the selection is accepted
  task automatic build(input int p);
    sched.delete();
    for (int i = 0; i < NI; i++) begin
      sched.push_back(0);
      repeat (rec[p][i] * TD) sched.push_back(1 << i);
    end
  endtask

  task automatic model_step();
    e_rej = 0; e_ins = 0; e_cv = 0; e_cu = 0;
    if (rst) begin
      m_mode = 0; m_credit = 0; m_change = 0;
      sched.delete();
      e_ing = 0; e_ready = 0;
    end else begin
      case (m_mode)
        0, 1: begin
          if (cancel && m_mode == 1) begin
            e_cv = 1; e_cu = m_credit;
            m_credit = 0; m_mode = 0;
            e_rej = int'(coin_valid);
          end else if (sel_valid) begin
            e_rej = int'(coin_valid);
            if (m_mode == 1 && m_credit >= prices[sel_id]) begin
              m_change = m_credit - prices[sel_id];
              m_credit = 0; m_mode = 2;
              build(int'(sel_id));
              e_ing = sched.pop_front();
            end else begin
              e_ins = 1;
            end
          end else if (coin_valid) begin
            if (m_credit + int'(coin_units) <= MAXC) begin
              m_credit += int'(coin_units); m_mode = 1;
            end else begin
              e_rej = 1;
            end
          end
        end
        2: begin
          e_rej = int'(coin_valid);
          if (sched.size() > 0) begin
            e_ing = sched.pop_front();
          end else begin
            e_ing = 0; m_mode = 3;
            e_ready = 1; e_cv = 1; e_cu = m_change;
          end
        end
        default: begin
          e_rej = int'(coin_valid);
          if (take) begin m_mode = 0; e_ready = 0; end
        end
      endcase
    end
    e_credit = m_credit;
    e_busy = (m_mode >= 2) ? 1 : 0;
  endtask

  task automatic compare();
    logic bad;
    bad = (ing_on !== NI'(e_ing)) || (drink_ready !== 1'(e_ready))
       || (credit !== CW'(e_credit)) || (change_valid !== 1'(e_cv))
       || (coin_reject !== 1'(e_rej)) || (insufficient !== 1'(e_ins))
       || (busy !== 1'(e_busy))
       || (e_cv == 1 && change_units !== CW'(e_cu));
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cycle t=%0t act ing=%b rdy=%b cr=%0d cv=%b cu=%0d rej=%b ins=%b busy=%b exp ing=%b rdy=%0d cr=%0d cv=%0d cu=%0d rej=%0d ins=%0d busy=%0d",
        $time, ing_on, drink_ready, credit, change_valid, change_units,
        coin_reject, insufficient, busy, NI'(e_ing), e_ready, e_credit,
        e_cv, e_cu, e_rej, e_ins, e_busy);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr_in();
    coin_valid = 0; coin_units = '0; sel_valid = 0; sel_id = '0;
    cancel = 0; take = 0; rst = 0;
  endtask

  task automatic coin(input int u);
    clr_in(); coin_valid = 1; coin_units = CW'(u); tick(); clr_in();
  endtask

  task automatic sel(input int p);
    clr_in(); sel_valid = 1; sel_id = 2'(p); tick(); clr_in();
  endtask

  task automatic do_cancel();
    clr_in(); cancel = 1; tick(); clr_in();
  endtask

  task automatic run_to_done(input int budget);
    int k;
    k = 0;
    for (int i = 0; i < NI; i++) on_cnt[i] = 0;
    clr_in();
    while (drink_ready !== 1'b1 && k < budget) begin
      tick();
      for (int i = 0; i < NI; i++) if (ing_on[i]) on_cnt[i]++;
      k++;
    end
    if (drink_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL dispense_timeout act=%b exp=1", drink_ready);
    end
  endtask

  initial begin
    int k;
    int vals[6] = '{1, 2, 3, 5, 7, 12};
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NI; i++)
        rec[p][i] = $urandom_range(0, 3);
    rec[2] = '{2, 1, 0, 0, 1};
    pack_tables();
    clr_in();
    rst = 1;
    tick(); tick();
    clr_in();
    lit("reset_credit", int'(credit), 0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_ing", int'(ing_on), 0);

    coin(5); coin(1);
    lit("credit_6", int'(credit), 6);
    sel(2);
    lit("credit_after_sel", int'(credit), 0);
    run_to_done(200);
    lit("ing0_cycles", on_cnt[0], 8);
    lit("ing1_cycles", on_cnt[1], 4);
    lit("ing4_cycles", on_cnt[4], 4);
    lit("done_change_valid", int'(change_valid), 1);
    lit("done_change_units", int'(change_units), 1);
    clr_in(); take = 1; tick(); clr_in();
    lit("take_idle", int'(busy), 0);

    coin(5); coin(5); coin(5);
    lit("overflow_reject", int'(coin_reject), 1);
    lit("overflow_credit", int'(credit), 10);
    coin(1);
    lit("credit_11", int'(credit), 11);
    do_cancel();

    coin(3); sel(3);
    lit("insufficient", int'(insufficient), 1);
    lit("insuff_credit", int'(credit), 3);
    do_cancel();

    coin(5); coin(1);
    clr_in(); cancel = 1; sel_valid = 1; sel_id = 2'd0;
    coin_valid = 1; coin_units = 8'd2;
    tick(); clr_in();
    lit("cancel_units", int'(change_units), 6);
    lit("cancel_reject", int'(coin_reject), 1);
    lit("cancel_credit", int'(credit), 0);

    coin(5); coin(2); sel(3);
    coin(1);
    lit("disp_coin_reject", int'(coin_reject), 1);
    lit("disp_credit", int'(credit), 0);
    run_to_done(300);
    lit("exact_cv", int'(change_valid), 1);
    lit("exact_cu", int'(change_units), 0);
    clr_in(); take = 1; tick(); clr_in();

    coin(5); coin(1); sel(2);
    k = 0;
    while (ing_on[1] !== 1'b1 && k < 100) begin tick(); k++; end
    lit("reach_ing1", int'(ing_on[1]), 1);
    clr_in(); rst = 1; tick(); clr_in();
    lit("rst_ing", int'(ing_on), 0);
    lit("rst_busy", int'(busy), 0);
    lit("rst_ready", int'(drink_ready), 0);
    coin(3);
    lit("post_rst_credit", int'(credit), 3);
    do_cancel();

    for (int n = 0; n < 4000; n++) begin
      clr_in();
      coin_valid = ($urandom_range(0, 99) < 30);
      coin_units = CW'(vals[$urandom_range(0, 5)]);
      sel_valid = ($urandom_range(0, 99) < 12);
      sel_id = 2'($urandom_range(0, 3));
      cancel = ($urandom_range(0, 99) < 4);
      take = ($urandom_range(0, 99) < 15);
      rst = ($urandom_range(0, 999) < 5);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
